// File: rtl/truth_table_scanner.sv
// Exhaustive stimulus/capture engine for an N_IN-input, 1-output combinational block.
// Define SCAN_CHECK_EN to compare the captured table against EXPECTED; otherwise the compare outputs read 0.
module truth_table_scanner #(
  parameter int                  N_IN     = 5,
  parameter int                  SETTLE   = 1,
  parameter logic [2**N_IN-1:0]  EXPECTED = 32'h9669_6996
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      stim,
  input  logic                 resp,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [N_IN-1:0]      first_fail,
  output logic                 pass
);

  localparam logic [3:0]      SETTLE_W = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST     = {N_IN{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE} state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_q;
  logic       last_code;

  assign last_code = (stim == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = (SETTLE_W != 4'd0) ? S_SETTLE : S_CAPTURE;
      S_SETTLE:  if (wait_q <= 4'd1) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (last_code)               state_d = S_IDLE;
        else if (SETTLE_W != 4'd0)   state_d = S_SETTLE;
        else                         state_d = S_CAPTURE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Stimulus, settle timer and capture; stim parks at the last code until restarted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      wait_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          stim      <= '0;
          table_out <= '0;
          busy      <= 1'b1;
          wait_q    <= SETTLE_W;
        end
        S_SETTLE: wait_q <= wait_q - 4'd1;
        S_CAPTURE: begin
          table_out[stim] <= resp;
          if (last_code) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            stim   <= stim + 1'b1;
            wait_q <= SETTLE_W;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SCAN_CHECK_EN
  logic          miss;
  logic [N_IN:0] cnt_nxt;

  assign miss    = resp ^ EXPECTED[stim];
  assign cnt_nxt = mismatch_cnt + {{N_IN{1'b0}}, miss};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt <= '0;
      first_fail   <= '0;
      pass         <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      mismatch_cnt <= '0;
      first_fail   <= '0;
      pass         <= 1'b0;
    end else if (state_q == S_CAPTURE) begin
      mismatch_cnt <= cnt_nxt;
      // A zero running count means this is the scan's first miss.
      if (miss && mismatch_cnt == '0) first_fail <= stim;
      if (last_code) pass <= (cnt_nxt == '0);
    end
  end
`else
  assign mismatch_cnt = '0;
  assign first_fail   = '0;
  assign pass         = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed checks of truth_table_scanner: three instances cover SETTLE = 1 (default), 2 and 0.
module tb_truth_table_scanner;

`ifdef SCAN_CHECK_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic       [2:0] start_v;
  logic             flip;
  wire        [2:0] resp_v;
  wire        [2:0] busy_v, done_v, pass_v;
  wire  [2:0] [4:0] stim_v, ff_v;
  wire  [2:0] [31:0] tbl_v;
  wire  [2:0] [5:0] mcnt_v;

  int n_chk = 0;
  int n_err = 0;
  int e;

  always #5 clk = ~clk;

  // Response models: parity (optionally corrupted at code 13), constant 1, parity.
  assign resp_v[0] = (^stim_v[0]) ^ (flip && stim_v[0] == 5'd13);
  assign resp_v[1] = 1'b1;
  assign resp_v[2] = ^stim_v[2];

  truth_table_scanner u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stim(stim_v[0]), .resp(resp_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .table_out(tbl_v[0]), .mismatch_cnt(mcnt_v[0]),
    .first_fail(ff_v[0]), .pass(pass_v[0]));

  truth_table_scanner #(.SETTLE(2), .EXPECTED(32'h0)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stim(stim_v[1]), .resp(resp_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .table_out(tbl_v[1]), .mismatch_cnt(mcnt_v[1]),
    .first_fail(ff_v[1]), .pass(pass_v[1]));

  truth_table_scanner #(.SETTLE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .stim(stim_v[2]), .resp(resp_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .table_out(tbl_v[2]), .mismatch_cnt(mcnt_v[2]),
    .first_fail(ff_v[2]), .pass(pass_v[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input int i, input string tag);
    check({tag, " stim"},  64'(stim_v[i]), 64'd0);
    check({tag, " busy"},  64'(busy_v[i]), 64'd0);
    check({tag, " done"},  64'(done_v[i]), 64'd0);
    check({tag, " table"}, 64'(tbl_v[i]),  64'd0);
    check({tag, " mcnt"},  64'(mcnt_v[i]), 64'd0);
    check({tag, " ff"},    64'(ff_v[i]),   64'd0);
    check({tag, " pass"},  64'(pass_v[i]), 64'd0);
  endtask

  // Start accepted at edge 0; returns the edge index after which done was seen.
  task automatic run_scan(input int i, input bit hold, input int pulse_at, output int edges);
    @(negedge clk);
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = hold;
    edges = 0;
    while (!done_v[i] && edges < 400) begin
      @(posedge clk); edges++; #1;
      if (edges == 1) check("busy_mid", 64'(busy_v[i]), 64'd1);
      start_v[i] = hold | (edges == pulse_at);
    end
  endtask

  task automatic chk_res(input string tag, input int i, input int edges, input int exp_edges,
                         input logic [31:0] tbl, input logic [5:0] mc, input logic [4:0] ff,
                         input bit ps);
    check({tag, " done"},  64'(done_v[i]), 64'd1);
    check({tag, " edges"}, 64'(edges),     64'(exp_edges));
    check({tag, " busy"},  64'(busy_v[i]), 64'd0);
    check({tag, " stim"},  64'(stim_v[i]), 64'd31);
    check({tag, " table"}, 64'(tbl_v[i]),  64'(tbl));
    check({tag, " mcnt"},  64'(mcnt_v[i]), 64'(mc));
    check({tag, " ff"},    64'(ff_v[i]),   64'(ff));
    check({tag, " pass"},  64'(pass_v[i]), 64'(ps));
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 64'(done_v[i]), 64'd0);
  endtask

  initial begin
    int n;
    rst_n   = 1'b1;
    start_v = '0;
    flip    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    chk_zero(2, "rst2");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_scan(0, 1'b0, -1, e);
    chk_res("parity", 0, e, 64, 32'h9669_6996, 6'd0, 5'd0, CK);

    flip = 1'b1;
    run_scan(0, 1'b0, 20, e);
    chk_res("flip13", 0, e, 64, 32'h9669_4996, CK ? 6'd1 : 6'd0, CK ? 5'd13 : 5'd0, 1'b0);
    flip = 1'b0;

    run_scan(1, 1'b0, -1, e);
    chk_res("ones_s2", 1, e, 96, 32'hFFFF_FFFF, CK ? 6'd32 : 6'd0, 5'd0, 1'b0);

    run_scan(2, 1'b0, -1, e);
    chk_res("parity_s0", 2, e, 32, 32'h9669_6996, 6'd0, 5'd0, CK);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    n = 0;
    while (stim_v[0] != 5'd10 && n < 100) begin
      @(posedge clk); n++; #1;
    end
    check("rst_wait stim", 64'(stim_v[0]), 64'd10);
    #2 rst_n = 1'b0;
    #1;
    chk_zero(0, "rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(0, 1'b0, -1, e);
    chk_res("after_rst", 0, e, 64, 32'h9669_6996, 6'd0, 5'd0, CK);

    // start held high: second scan accepted the edge after done.
    run_scan(0, 1'b1, -1, e);
    chk_res("hold1", 0, e, 64, 32'h9669_6996, 6'd0, 5'd0, CK);
    check("hold2 busy",  64'(busy_v[0]), 64'd1);
    check("hold2 stim",  64'(stim_v[0]), 64'd0);
    check("hold2 table", 64'(tbl_v[0]),  64'd0);
    e = 0;
    while (!done_v[0] && e < 400) begin
      @(posedge clk); e++; #1;
    end
    start_v[0] = 1'b0;
    chk_res("hold2", 0, e, 64, 32'h9669_6996, 6'd0, 5'd0, CK);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
